// File: rtl/dest_reg_pipe_if.sv
// Bundle between the ID stage and the register-address pipeline and hazard unit.
// The master side drives the ID-stage addresses and control; the slave side is the pipeline.
interface dest_reg_pipe_if #(
  parameter int unsigned AW = 5
);
  logic [AW-1:0] id_rd;
  logic [AW-1:0] id_rn;
  logic [AW-1:0] id_rm;
  logic          id_regwrite;
  logic          id_memread;
  logic          flush;
  logic          stall_req;
  logic [AW-1:0] ex_rd;
  logic [AW-1:0] mem_rd;
  logic          mem_regwrite;
  logic [AW-1:0] wb_rd;
  logic          wb_regwrite;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;

  modport master (
    output id_rd, id_rn, id_rm, id_regwrite, id_memread, flush,
    input  stall_req, ex_rd, mem_rd, mem_regwrite, wb_rd, wb_regwrite, fwd_a, fwd_b
  );

  modport slave (
    input  id_rd, id_rn, id_rm, id_regwrite, id_memread, flush,
    output stall_req, ex_rd, mem_rd, mem_regwrite, wb_rd, wb_regwrite, fwd_a, fwd_b
  );
endinterface

// File: rtl/dest_reg_pipe.sv
// Destination-register pipeline ID->EX->MEM->WB with EX forwarding selects and load-use stall.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining DEST_PIPE_PERF_EN.
module dest_reg_pipe #(
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  dest_reg_pipe_if.slave   pipe
`ifdef DEST_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [AW-1:0] Zero = AW'(ZERO_REG);

  logic [AW-1:0] ex_rd_q, ex_rn_q, ex_rm_q, mem_rd_q, wb_rd_q;
  logic          ex_regwrite_q, ex_memread_q, mem_regwrite_q, wb_regwrite_q;
  logic          stall;

  always_comb begin
    stall = ex_memread_q && (ex_rd_q != Zero) &&
            ((pipe.id_rn == ex_rd_q) || (pipe.id_rm == ex_rd_q));
  end

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                         input logic [AW-1:0] m_rd, input logic m_we,
                                         input logic [AW-1:0] w_rd, input logic w_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_rd == src) && (m_rd != Zero)) begin
      sel = 2'b10;
    end else if (w_we && (w_rd == src) && (w_rd != Zero)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    pipe.stall_req    = stall;
    pipe.ex_rd        = ex_rd_q;
    pipe.mem_rd       = mem_rd_q;
    pipe.mem_regwrite = mem_regwrite_q;
    pipe.wb_rd        = wb_rd_q;
    pipe.wb_regwrite  = wb_regwrite_q;
    pipe.fwd_a        = fwd_sel(ex_rn_q, mem_rd_q, mem_regwrite_q, wb_rd_q, wb_regwrite_q);
    pipe.fwd_b        = fwd_sel(ex_rm_q, mem_rd_q, mem_regwrite_q, wb_rd_q, wb_regwrite_q);
  end

  // Flush and stall both turn the ID->EX transfer into a bubble; flush wins only in intent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q        <= Zero;
      ex_rn_q        <= Zero;
      ex_rm_q        <= Zero;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= Zero;
      mem_regwrite_q <= 1'b0;
      wb_rd_q        <= Zero;
      wb_regwrite_q  <= 1'b0;
    end else begin
      if (pipe.flush || stall) begin
        ex_rd_q       <= Zero;
        ex_rn_q       <= Zero;
        ex_rm_q       <= Zero;
        ex_regwrite_q <= 1'b0;
        ex_memread_q  <= 1'b0;
      end else begin
        ex_rd_q       <= pipe.id_rd;
        ex_rn_q       <= pipe.id_rn;
        ex_rm_q       <= pipe.id_rm;
        ex_regwrite_q <= pipe.id_regwrite;
        ex_memread_q  <= pipe.id_memread;
      end
      mem_rd_q       <= ex_rd_q;
      mem_regwrite_q <= ex_regwrite_q;
      wb_rd_q        <= mem_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
    end
  end

`ifdef DEST_PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CntOne;
      end
      if (pipe.flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CntOne;
      end
    end
  end
`endif

endmodule
